// File: rtl/spatial_filter_pkg.sv
// Shared types and constants for the spatial filter frame sequencer.
package spatial_filter_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PRIME  = 2'd1,
    ST_STREAM = 2'd2,
    ST_DRAIN  = 2'd3
  } state_t;

  localparam int KERNEL_ROWS  = 3;
  localparam int LB_LINES_DEF = 4;

  typedef struct packed {
    logic wr;
    logic wr_eol;
    logic rd;
    logic rd_eol;
  } beat_t;
endpackage

// File: rtl/spf_credit_counter.sv
// Outstanding read-beat counter against the output FIFO; a pop with nothing outstanding is dropped.
module spf_credit_counter #(
  parameter int DEPTH = 32,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          has_credit
);
  logic dec_ok;

  assign dec_ok     = dec && (count != '0);
  assign has_credit = count < CW'(DEPTH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  count <= '0;
    else if (clr)             count <= '0;
    else if (inc && !dec_ok)  count <= count + 1'b1;
    else if (!inc && dec_ok)  count <= count - 1'b1;
  end
endmodule

// File: rtl/spatial_filter_frame_ctrl.sv
// Frame sequencer: gates the pixel source, issues 3x3 window reads, tracks lines.
// SPATIAL_FILTER_STICKY_INTR_EN selects a sticky o_intr level instead of a per-line pulse.
module spatial_filter_frame_ctrl
  import spatial_filter_pkg::*;
#(
  parameter int IMAGE_WIDTH  = 512,
  parameter int IMAGE_HEIGHT = 512,
  parameter int FIFO_DEPTH   = 32,
  parameter int LB_LINES     = LB_LINES_DEF
) (
  input  logic       axis_clk,
  input  logic       axis_reset,
  input  logic       i_start,
  input  logic       i_s_data_valid,
  output logic       o_s_ready,
  output logic       o_lb_wr_en,
  output logic       o_lb_rd_en,
  input  logic       i_fifo_pop,
  output logic       o_intr,
  input  logic       i_intr_clr,
  output logic       o_frame_done,
  output logic [1:0] o_state,
  output logic       o_busy
);
  localparam int XW = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam int LW = $clog2(IMAGE_HEIGHT + 1);
  localparam int OW = $clog2(FIFO_DEPTH + 1);
  localparam logic [XW-1:0] X_LAST     = XW'(IMAGE_WIDTH - 1);
  localparam logic [LW-1:0] H_END      = LW'(IMAGE_HEIGHT);
  localparam logic [LW-1:0] RD_END     = LW'(IMAGE_HEIGHT - KERNEL_ROWS + 1);
  localparam logic [LW-1:0] PRIME_LAST = LW'(KERNEL_ROWS - 1);
  localparam logic [2:0]    LB_FULL    = 3'(LB_LINES);
  localparam logic [2:0]    K_ROWS     = 3'(KERNEL_ROWS);
  localparam bit            PRIME_TO_DRAIN = (IMAGE_HEIGHT == KERNEL_ROWS);

  state_t          state;
  logic [XW-1:0]   wr_col, rd_col;
  logic [LW-1:0]   wr_line, rd_line;
  logic [2:0]      filled;
  logic [OW-1:0]   outstanding;
  logic            has_credit;
  logic            start_go;
  beat_t           bt;

  assign o_s_ready  = (state == ST_PRIME || state == ST_STREAM) &&
                      (filled < LB_FULL) && (wr_line < H_END);
  assign o_lb_wr_en = i_s_data_valid && o_s_ready;
  assign o_lb_rd_en = (state == ST_STREAM || state == ST_DRAIN) &&
                      (filled >= K_ROWS) && has_credit && (rd_line < RD_END);
  assign o_state    = state;
  assign o_busy     = (state != ST_IDLE);
  assign start_go   = (state == ST_IDLE) && i_start;

  assign bt.wr     = o_lb_wr_en;
  assign bt.wr_eol = o_lb_wr_en && (wr_col == X_LAST);
  assign bt.rd     = o_lb_rd_en;
  assign bt.rd_eol = o_lb_rd_en && (rd_col == X_LAST);

  spf_credit_counter #(.DEPTH(FIFO_DEPTH), .CW(OW)) u_credit (
    .clk        (axis_clk),
    .rst        (axis_reset),
    .clr        (start_go),
    .inc        (bt.rd),
    .dec        (i_fifo_pop),
    .count      (outstanding),
    .has_credit (has_credit)
  );

  always_ff @(posedge axis_clk or posedge axis_reset) begin
    if (axis_reset) begin
      state        <= ST_IDLE;
      wr_col       <= '0;
      rd_col       <= '0;
      wr_line      <= '0;
      rd_line      <= '0;
      filled       <= '0;
      o_frame_done <= 1'b0;
    end else begin
      o_frame_done <= 1'b0;
      if (bt.wr)     wr_col  <= bt.wr_eol ? '0 : wr_col + 1'b1;
      if (bt.wr_eol) wr_line <= wr_line + 1'b1;
      if (bt.rd)     rd_col  <= bt.rd_eol ? '0 : rd_col + 1'b1;
      if (bt.rd_eol) rd_line <= rd_line + 1'b1;
      // A line arriving and a line retiring together leave occupancy unchanged.
      case ({bt.wr_eol, bt.rd_eol})
        2'b10:   filled <= filled + 1'b1;
        2'b01:   filled <= filled - 1'b1;
        default: ;
      endcase
      case (state)
        ST_IDLE: if (i_start) begin
          state   <= ST_PRIME;
          wr_col  <= '0;
          rd_col  <= '0;
          wr_line <= '0;
          rd_line <= '0;
          filled  <= '0;
        end
        ST_PRIME: if (bt.wr_eol && wr_line == PRIME_LAST)
          state <= PRIME_TO_DRAIN ? ST_DRAIN : ST_STREAM;
        ST_STREAM: if (wr_line == H_END) state <= ST_DRAIN;
        ST_DRAIN: if (rd_line == RD_END && outstanding == '0) begin
          state        <= ST_IDLE;
          o_frame_done <= 1'b1;
          filled       <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef SPATIAL_FILTER_STICKY_INTR_EN
  always_ff @(posedge axis_clk or posedge axis_reset) begin
    if (axis_reset)      o_intr <= 1'b0;
    else if (bt.rd_eol)  o_intr <= 1'b1;
    else if (i_intr_clr) o_intr <= 1'b0;
  end
`else
  logic unused_intr_clr;
  assign unused_intr_clr = i_intr_clr;

  always_ff @(posedge axis_clk or posedge axis_reset) begin
    if (axis_reset) o_intr <= 1'b0;
    else            o_intr <= bt.rd_eol;
  end
`endif
endmodule
